sort4_stream: RTL
=================

SORT4_STREAM -- requirements
Module: sort4_stream

Interface
REQ-001 Parameter: WIDTH, 4, bit width of each data element.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream element present on in_data.
REQ-005 Port: in_data  input  WIDTH  unsigned element.
REQ-006 Port: in_ready  output  1  block accepts an element this cycle.
REQ-007 Port: out_valid  output  1  sorted element present on out_data.
REQ-008 Port: out_data  output  WIDTH  sorted element, ascending order.
REQ-009 Port: out_last  output  1  marks the 4th (largest) element of a frame.
REQ-010 Port: out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-011 Frame SHALL be exactly 4 elements; input handshake = in_valid && in_ready at a rising edge.
REQ-012 FSM states SHALL be COLLECT, SORT, EMIT; only these transitions: COLLECT->SORT, SORT->EMIT, EMIT->COLLECT.
REQ-013 COLLECT: in_ready = 1; each handshake stores in_data at slot index (0..3, 2-bit counter); counter increments per handshake only.
REQ-014 COLLECT->SORT on the 4th input handshake; counter SHALL wrap to 0.
REQ-015 in_valid without in_ready SHALL have no effect; in_data is don't-care when in_valid = 0.
REQ-016 SORT: in_ready = 0, out_valid = 0; 4-input network of 5 compare-swaps in 3 registered layers: L1 (0,1),(2,3); L2 (0,2),(1,3); L3 (1,2).
REQ-017 Each compare-swap SHALL output min on the lower index, max on the higher; unsigned compare, WIDTH bits, no widening.
REQ-018 SORT SHALL last exactly 3 cycles; out_valid SHALL first assert 3 cycles after the edge accepting the 4th element.
REQ-019 EMIT: out_valid = 1, in_ready = 0; out_data = sorted[k], k = 0..3, smallest first.
REQ-020 k SHALL advance only on out_valid && out_ready; out_data/out_last SHALL hold stable while out_ready = 0.
REQ-021 out_last = 1 exactly when k = 3; on that handshake state->COLLECT and in_ready = 1 in the following cycle.
REQ-022 Equal elements SHALL all be emitted (duplicates preserved, 4 outputs per frame always).
REQ-023 Minimum frame period SHALL be 11 cycles (4 collect + 3 sort + 4 emit) with continuous valid/ready.
REQ-024 out_data SHALL be 0 whenever out_valid = 0.

Reset
REQ-025 On rst = 1 at a rising edge: state = COLLECT, counters = 0, slot/layer registers = 0.
REQ-026 During and after reset: in_ready = 1 (first cycle after rst deasserts), out_valid = 0, out_last = 0, out_data = 0.
REQ-027 Reset in any state (mid-collect, mid-sort, mid-emit) SHALL discard the partial frame; no element of it is later emitted.
REQ-028 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-029 Shared package sort_pkg SHALL hold: FRAME_LEN = 4, SORT_LAYERS = 3, state enum type (COLLECT/SORT/EMIT).
REQ-030 One sub-module sort4_cas (WIDTH-parameterised combinational compare-swap) SHALL be instantiated 5 times; layer registers live in sort4_stream.
REQ-031 All outputs SHALL be driven from registers or state decode only; no combinational path from in_* to out_* or from out_ready to in_ready.

Verification
REQ-032 Inputs 3,2,15,8 back-to-back, out_ready = 1 -> outputs 2,3,8,15; out_last on 15; out_valid rises 3 cycles after 4th accept.
REQ-033 Inputs 6,6,6,0 -> outputs 0,6,6,6; four output handshakes, out_last only on the 4th.
REQ-034 Frame 15,11,8,0 with out_ready toggling 1,0,0,1,0,1,1 -> outputs 0,8,11,15, out_data stable through each stall, no drop/duplicate.
REQ-035 Two frames (1,0,3,2) then (9,9,4,12), in_valid held 1 -> in_ready low during SORT/EMIT; outputs 0,1,2,3 then 4,9,9,12; period 11 cycles.
REQ-036 rst asserted after 2nd input accept and again during EMIT at k = 1 -> out_valid = 0 next cycle, in_ready = 1; next frame 5,4,7,1 -> outputs 1,4,5,7 only.
REQ-037 All 16x16 value pairs in slots 0/1 with slots 2/3 = 0,15 -> every frame output non-decreasing and a permutation of the inputs.

Source files
------------

// File: rtl/sort_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the sort4_stream block.
//   FRAME_LEN   : number of elements collected, sorted and emitted per frame
//   SORT_LAYERS : number of registered compare-swap layers in the network
//   LAST_SLOT   : index of the final slot / final output of a frame
//   LAST_LAYER  : value of the sort-layer counter on the final SORT cycle
//   state_t     : control FSM states (COLLECT -> SORT -> EMIT -> COLLECT)
// ---------------------------------------------------------------------------
package sort_pkg;

    localparam int FRAME_LEN   = 4;
    localparam int SORT_LAYERS = 3;

    // 2-bit counter terminal values derived from the frame/network sizes
    localparam logic [1:0] LAST_SLOT  = 2'(FRAME_LEN - 1);
    localparam logic [1:0] LAST_LAYER = 2'(SORT_LAYERS - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SORT    = 2'd1,
        EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/sort4_cas.sv
// ---------------------------------------------------------------------------
// sort4_cas
// Purely combinational compare-swap element for the 4-input sorting network.
// The smaller operand appears on lo, the larger on hi. Comparison is
// unsigned at exactly WIDTH bits.
//
// Ports
//   a  : input  [WIDTH-1:0]  operand from the lower network index
//   b  : input  [WIDTH-1:0]  operand from the higher network index
//   lo : output [WIDTH-1:0]  min(a, b), goes to the lower index
//   hi : output [WIDTH-1:0]  max(a, b), goes to the higher index
// ---------------------------------------------------------------------------
module sort4_cas #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic swap;

    // Swap only when strictly out of order so equal values pass straight
    // through; either choice is correct, this one keeps the mux simple.
    always_comb begin
        swap = (b < a);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/sort4_stream.sv
// ---------------------------------------------------------------------------
// sort4_stream
// Streaming 4-element sorter. Collects a frame of four unsigned elements via
// a valid/ready input handshake, sorts them through a 3-layer registered
// compare-swap network, then emits them smallest-first on a valid/ready
// output handshake, flagging the largest element with out_last.
//
// Ports
//   clk       : input         single clock, rising edge
//   rst       : input         synchronous active-high reset
//   in_valid  : input         element present on in_data
//   in_data   : input  [W-1]  unsigned element
//   in_ready  : output        block accepts an element this cycle (COLLECT)
//   out_valid : output        sorted element present on out_data (EMIT)
//   out_data  : output [W-1]  sorted element, ascending; 0 when not valid
//   out_last  : output        marks the 4th (largest) element of a frame
//   out_ready : input         downstream accepts out_data this cycle
//
// All outputs decode from registered state only, so there is no
// combinational path from in_* to out_* or from out_ready to in_ready.
// ---------------------------------------------------------------------------
module sort4_stream
    import sort_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    state_t state_q, state_d;

    logic [1:0] in_cnt_q,   in_cnt_d;
    logic [1:0] sort_cnt_q, sort_cnt_d;
    logic [1:0] out_idx_q,  out_idx_d;

    // Input slots and the three network layer registers
    logic [WIDTH-1:0] slot_q [FRAME_LEN];
    logic [WIDTH-1:0] slot_d [FRAME_LEN];
    logic [WIDTH-1:0] l1_q   [FRAME_LEN];
    logic [WIDTH-1:0] l1_d   [FRAME_LEN];
    logic [WIDTH-1:0] l2_q   [FRAME_LEN];
    logic [WIDTH-1:0] l2_d   [FRAME_LEN];
    logic [WIDTH-1:0] l3_q   [FRAME_LEN];
    logic [WIDTH-1:0] l3_d   [FRAME_LEN];

    // Compare-swap results feeding each layer register
    logic [WIDTH-1:0] l1_lo_01, l1_hi_01, l1_lo_23, l1_hi_23;
    logic [WIDTH-1:0] l2_lo_02, l2_hi_02, l2_lo_13, l2_hi_13;
    logic [WIDTH-1:0] l3_lo_12, l3_hi_12;

    logic in_fire;
    logic out_fire;

    // Layer 1: pairs (0,1) and (2,3) straight from the collected slots
    sort4_cas #(.WIDTH(WIDTH)) u_cas_l1_01 (
        .a  (slot_q[0]),
        .b  (slot_q[1]),
        .lo (l1_lo_01),
        .hi (l1_hi_01)
    );

    sort4_cas #(.WIDTH(WIDTH)) u_cas_l1_23 (
        .a  (slot_q[2]),
        .b  (slot_q[3]),
        .lo (l1_lo_23),
        .hi (l1_hi_23)
    );

    // Layer 2: (0,2) settles the global minimum, (1,3) the global maximum
    sort4_cas #(.WIDTH(WIDTH)) u_cas_l2_02 (
        .a  (l1_q[0]),
        .b  (l1_q[2]),
        .lo (l2_lo_02),
        .hi (l2_hi_02)
    );

    sort4_cas #(.WIDTH(WIDTH)) u_cas_l2_13 (
        .a  (l1_q[1]),
        .b  (l1_q[3]),
        .lo (l2_lo_13),
        .hi (l2_hi_13)
    );

    // Layer 3: only the two middle elements can still be out of order
    sort4_cas #(.WIDTH(WIDTH)) u_cas_l3_12 (
        .a  (l2_q[1]),
        .b  (l2_q[2]),
        .lo (l3_lo_12),
        .hi (l3_hi_12)
    );

    // Output decode: everything here depends on registered state only
    always_comb begin
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == EMIT);
        out_last  = out_valid && (out_idx_q == LAST_SLOT);
        out_data  = out_valid ? l3_q[out_idx_q] : '0;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    // Next-state logic. The layer registers advance on every SORT cycle, so
    // after three SORT cycles the data has walked L1 -> L2 -> L3 and l3_q
    // holds the fully sorted frame by the time EMIT begins.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        sort_cnt_d = sort_cnt_q;
        out_idx_d  = out_idx_q;
        slot_d     = slot_q;
        l1_d       = l1_q;
        l2_d       = l2_q;
        l3_d       = l3_q;

        unique case (state_q)
            COLLECT: begin
                if (in_fire) begin
                    slot_d[in_cnt_q] = in_data;
                    // 2-bit counter wraps to 0 after the 4th element
                    in_cnt_d = in_cnt_q + 2'd1;
                    if (in_cnt_q == LAST_SLOT) begin
                        state_d    = SORT;
                        sort_cnt_d = 2'd0;
                    end
                end
            end

            SORT: begin
                l1_d[0] = l1_lo_01;
                l1_d[1] = l1_hi_01;
                l1_d[2] = l1_lo_23;
                l1_d[3] = l1_hi_23;

                l2_d[0] = l2_lo_02;
                l2_d[1] = l2_lo_13;
                l2_d[2] = l2_hi_02;
                l2_d[3] = l2_hi_13;

                l3_d[0] = l2_q[0];
                l3_d[1] = l3_lo_12;
                l3_d[2] = l3_hi_12;
                l3_d[3] = l2_q[3];

                sort_cnt_d = sort_cnt_q + 2'd1;
                if (sort_cnt_q == LAST_LAYER) begin
                    state_d    = EMIT;
                    sort_cnt_d = 2'd0;
                    out_idx_d  = 2'd0;
                end
            end

            EMIT: begin
                if (out_fire) begin
                    if (out_idx_q == LAST_SLOT) begin
                        state_d   = COLLECT;
                        out_idx_d = 2'd0;
                    end else begin
                        out_idx_d = out_idx_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State register. Reset wipes every slot and layer so that no element of
    // an interrupted frame can ever resurface in a later one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            in_cnt_q   <= 2'd0;
            sort_cnt_q <= 2'd0;
            out_idx_q  <= 2'd0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                slot_q[i] <= '0;
                l1_q[i]   <= '0;
                l2_q[i]   <= '0;
                l3_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            sort_cnt_q <= sort_cnt_d;
            out_idx_q  <= out_idx_d;
            slot_q     <= slot_d;
            l1_q       <= l1_d;
            l2_q       <= l2_d;
            l3_q       <= l3_d;
        end
    end

endmodule
